// File: rtl/timing_gen.sv
// timing_gen: one-hot beat generator for the hardwired controller, with run/step/halt
// control and a retired-instruction counter.
module timing_gen #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          step,
    input  logic          ins_end,
    input  logic          halt,
    output logic          T0,
    output logic          T1,
    output logic          T2,
    output logic          T3,
    output logic          T4,
    output logic          T5,
    output logic          T6,
    output logic          T7,
    output logic [2:0]    beat,
    output logic          running,
    output logic          halted,
    output logic [CW-1:0] ins_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;
    state_t     state;
    logic [7:0] t;
    logic       fin;
    logic       stop;
    assign {T7, T6, T5, T4, T3, T2, T1, T0} = t;
    // fetch beats T0..T2 never end an instruction; halt implies end
    assign stop = beat >= 3'd3 && halt;
    assign fin  = beat == 3'd7 || (beat >= 3'd3 && ins_end) || stop;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            t       <= '0;
            beat    <= '0;
            running <= 1'b0;
            halted  <= 1'b0;
            ins_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (run || step) begin
                    state   <= run ? RUN : STEP;
                    t       <= 8'd1;
                    beat    <= '0;
                    running <= 1'b1;
                end
                RUN, STEP: if (fin) begin
                    ins_cnt <= ins_cnt + 1'b1;
                    beat    <= '0;
                    if (stop) begin
                        state   <= HALTED;
                        t       <= '0;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else if (state == RUN && run) begin
                        t <= 8'd1;
                    end else begin
                        state   <= IDLE;
                        t       <= '0;
                        running <= 1'b0;
                    end
                end else begin
                    beat <= beat + 3'd1;
                    t    <= t << 1;
                end
                default: ;
            endcase
        end
    end
endmodule
